// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: load/store width encodings and alignment rule.
package mips_pkg;

  localparam int LANE_SEL_W = 2;

  localparam logic [2:0] SL_WORD  = 3'd0;
  localparam logic [2:0] SL_HALFU = 3'd1;
  localparam logic [2:0] SL_HALFS = 3'd2;
  localparam logic [2:0] SL_BYTEU = 3'd3;
  localparam logic [2:0] SL_BYTES = 3'd4;

  // Reserved encodings fall into the default arm and behave as word accesses.
  function automatic logic is_misaligned(input logic [LANE_SEL_W-1:0] lane,
                                         input logic [2:0] slctrl);
    case (slctrl)
      SL_HALFU, SL_HALFS: return lane[0];
      SL_BYTEU, SL_BYTES: return 1'b0;
      default:            return lane != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_ext.sv
// Load path: pick the addressed byte/half out of a word and zero/sign extend it.
module load_ext
  import mips_pkg::*;
(
  input  logic [31:0]           word,
  input  logic [LANE_SEL_W-1:0] lane,
  input  logic [2:0]            slctrl,
  output logic [31:0]           value
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  always_comb begin
    half_v = lane[1] ? word[31:16] : word[15:0];
    byte_v = word[7:0];
    case (lane)
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
  end

  always_comb begin
    value = word;
    case (slctrl)
      SL_HALFU: value = {16'h0000, half_v};
      SL_HALFS: value = {{16{half_v[15]}}, half_v};
      SL_BYTEU: value = {24'h000000, byte_v};
      SL_BYTES: value = {{24{byte_v[7]}}, byte_v};
      default:  value = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data memory with byte-lane store merge and extended combinational loads.
module mem_stage
  import mips_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic        DMWE,
  input  logic [2:0]  SLCtrl,
  input  logic [31:0] PC,
  output logic [31:0] RD,
  output logic        AddrErr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           old_word;
  logic [31:0]           new_word;
  logic [31:0]           lane_data;
  logic [3:0]            be;
  logic [31:0]           ext_word;
  logic                  we;

  assign idx      = Addr[DEPTH_LOG2+1:2];
  assign old_word = mem[idx];
  assign AddrErr  = is_misaligned(Addr[1:0], SLCtrl);
  assign we       = DMWE && !AddrErr;

  // Replicate the store data across lanes so the byte enables alone pick the target.
  always_comb begin
    be        = 4'b1111;
    lane_data = WD;
    case (SLCtrl)
      SL_HALFU, SL_HALFS: begin
        be        = Addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{WD[15:0]}};
      end
      SL_BYTEU, SL_BYTES: begin
        be        = 4'b0001 << Addr[1:0];
        lane_data = {4{WD[7:0]}};
      end
      default: begin
        be        = 4'b1111;
        lane_data = WD;
      end
    endcase
  end

  always_comb begin
    new_word = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) new_word[8*b +: 8] = lane_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= new_word;
    end
  end

  load_ext u_load_ext (
    .word   (old_word),
    .lane   (Addr[1:0]),
    .slctrl (SLCtrl),
    .value  (ext_word)
  );

  assign RD = AddrErr ? 32'h0 : ext_word;

`ifndef SYNTHESIS
  // Store trace for comparison against the reference simulator.
  always @(posedge clk) begin
    if (!reset && we)
      $display("@%08h: *%08h <= %08h", PC, {Addr[31:2], 2'b00}, new_word);
  end
`endif

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM pipeline register. It holds the data memory, performs word/halfword/byte stores with byte-lane merging, and returns sign- or zero-extended load data to the MEM/WB register. Writes are synchronous; reads are combinational, so load data is valid in the same cycle the address is presented.

## Interface
Parameters:
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KiB)

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears the entire memory
- Addr  input  32  byte address (ALU result from EX/MEM)
- WD  input  32  store data (forwarded rt value from EX/MEM)
- DMWE  input  1  store enable
- SLCtrl  input  3  access width/extension select
- PC  input  32  PC of the instruction in MEM; used only for the store trace
- RD  output  32  extended load data, combinational
- AddrErr  output  1  misaligned access flag, combinational

## Operation
- SLCtrl encoding:
  - 0: word
  - 1: half, zero-extended
  - 2: half, sign-extended
  - 3: byte, zero-extended
  - 4: byte, sign-extended
  - 5–7: reserved, treated exactly as 0
- Word index = Addr[DEPTH_LOG2+1:2]. Higher address bits are ignored, so addresses wrap modulo memory size.
- Alignment:
  - Word access with Addr[1:0]≠0 → AddrErr=1.
  - Half access with Addr[0]=1 → AddrErr=1.
  - Byte access is never misaligned.
- Store, when DMWE=1 and AddrErr=0:
  - Word: write WD to all four lanes.
  - Half: write WD[15:0] to lanes {Addr[1],0}..+1.
  - Byte: write WD[7:0] to lane Addr[1:0].
  - Lanes not selected keep their previous contents.
  - Lane 0 = bits [7:0] (little-endian).
- Misaligned store: no memory change. AddrErr is still asserted.
- Load (always computed, independent of DMWE):
  - Select the word, then the lane(s) per Addr[1:0], then extend per SLCtrl.
  - Misaligned → RD=0.
- Trace: on every committed store, print the simulation-only line "@PC: *Addr_word_aligned <= new_word" (new_word = full merged word). No trace on suppressed stores or during reset.

## Timing
- Memory write commits at the rising edge where DMWE=1, AddrErr=0, reset=0.
- RD reflects memory contents before that edge: read-during-write returns old data. The new data is visible the cycle after.
- Load latency: 0 cycles (combinational). The MEM/WB register captures RD at the next edge.
- Reset: at a rising edge with reset=1:
  - All words become 0.
  - Any concurrent store is discarded; reset wins.
- Reset values of outputs (from the cycle after the reset edge):
  - RD=0 for any address.
  - AddrErr depends only on the current inputs.
- No handshake and no stall: the stage accepts one access per cycle unconditionally.

## Structure
- Shared package mips_pkg holds:
  - SLCtrl encodings: SL_WORD, SL_HALFU, SL_HALFS, SL_BYTEU, SL_BYTES.
  - The lane-select width constant.
  - The EX/MEM register also uses these encodings.
- Sub-module load_ext: combinational lane select plus zero/sign extension. Inputs are the word, Addr[1:0] and SLCtrl; output is the 32-bit value.
- The store merge and memory array remain in mem_stage.

## Test plan
- Reset, then word store WD=0x12345678 at Addr=0x10 (PC=0x3000) → trace "@00003000: *00000010 <= 12345678". Next cycle, word load at 0x10 → RD=0x12345678.
- After the above, byte store WD=0xAB at 0x13 → word becomes 0xAB345678. Load byte-signed at 0x13 → RD=0xFFFFFFAB. Byte-unsigned → RD=0x000000AB.
- Half store WD=0x8001 at 0x12 → word becomes 0x80015678. Half-signed load at 0x12 → 0xFFFF8001. Half-unsigned load at 0x10 → 0x00005678.
- Word store at 0x22 with DMWE=1 → AddrErr=1, RD=0, memory unchanged, no trace. Half load at 0x11 → AddrErr=1, RD=0.
- Store 0xDEADBEEF to 0x40 in the same cycle that reset=1 → after that edge, load at 0x40 returns 0. A store to Addr=0x1040 (DEPTH_LOG2=10) aliases word 0x40.
- Back-to-back cycles: store 0x1 at 0x8, then load 0x8 in the same cycle as a store of 0x2 to 0x8 → RD=0x1 in that cycle and 0x2 in the following cycle.
